// File: rtl/barrel_fetch_pkg.sv
// Shared constants for the barrel fetch unit: hart-index width, instruction size, default reset PC.
package barrel_fetch_pkg;

    localparam int DEFAULT_NUM_HARTS = 4;
    localparam int HART_IDX_W        = $clog2(DEFAULT_NUM_HARTS);
    localparam int INSTR_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Hart-index width for an arbitrary (power-of-two) hart count
    function automatic int hart_idx_w(input int num_harts);
        return (num_harts > 1) ? $clog2(num_harts) : 1;
    endfunction

endpackage

// File: rtl/hart_pc_file.sv
// Per-hart PC register file: one read port, an increment write port and a
// redirect write port that takes priority over the increment on the same entry.
module hart_pc_file
    import barrel_fetch_pkg::*;
#(
    parameter int                       NUM_HARTS     = DEFAULT_NUM_HARTS,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [$clog2(NUM_HARTS)-1:0]  rd_idx,
    output logic [ADDRESS_WIDTH-1:0]      rd_pc,
    input  logic                          inc_en,
    input  logic [$clog2(NUM_HARTS)-1:0]  inc_idx,
    input  logic                          redir_en,
    input  logic [$clog2(NUM_HARTS)-1:0]  redir_idx,
    input  logic [ADDRESS_WIDTH-1:0]      redir_pc
);

    localparam int HW = hart_idx_w(NUM_HARTS);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(INSTR_BYTES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] PC_STEP    = ADDRESS_WIDTH'(INSTR_BYTES);

    logic [ADDRESS_WIDTH-1:0] pc_r     [NUM_HARTS];
    logic [ADDRESS_WIDTH-1:0] pc_nxt_s [NUM_HARTS];

    assign rd_pc = pc_r[rd_idx];

    // Next PC per hart: a redirect overrides the +4 of an issue to the same hart
    always_comb begin
        for (int i = 0; i < NUM_HARTS; i++) begin
            pc_nxt_s[i] = pc_r[i];
            if (redir_en && (redir_idx == HW'(i))) begin
                pc_nxt_s[i] = redir_pc & ALIGN_MASK;
            end else if (inc_en && (inc_idx == HW'(i))) begin
                pc_nxt_s[i] = pc_r[i] + PC_STEP;
            end else begin
                pc_nxt_s[i] = pc_r[i];
            end
        end
    end

    // PC storage with synchronous active-low reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (!rst_n) begin
                pc_r[i] <= RESET_PC;
            end else begin
                pc_r[i] <= pc_nxt_s[i];
            end
        end
    end

endmodule

// File: rtl/barrel_fetch.sv
// Round-robin barrel fetch: one instruction per cycle from interleaved harts into a
// registered valid/ready output. Optional stall counter enabled by FETCH_STALL_CNT_EN.
module barrel_fetch
    import barrel_fetch_pkg::*;
#(
    parameter int                       NUM_HARTS     = DEFAULT_NUM_HARTS,
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [ADDRESS_WIDTH-1:0]      instr_addr,
    input  logic [DATA_WIDTH-1:0]         instr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_instr,
    output logic [ADDRESS_WIDTH-1:0]      out_pc,
    output logic [$clog2(NUM_HARTS)-1:0]  out_hart,
    input  logic                          redirect_valid,
    input  logic [$clog2(NUM_HARTS)-1:0]  redirect_hart,
`ifdef FETCH_STALL_CNT_EN
    input  logic [ADDRESS_WIDTH-1:0]      redirect_pc,
    output logic [31:0]                   stall_cnt
`else
    input  logic [ADDRESS_WIDTH-1:0]      redirect_pc
`endif
);

    localparam int HW = hart_idx_w(NUM_HARTS);

    logic [HW-1:0]            cur_hart_r;
    logic [ADDRESS_WIDTH-1:0] cur_pc_s;
    logic                     issue_s;

    assign issue_s    = !out_valid || out_ready;
    assign instr_addr = cur_pc_s;

    hart_pc_file #(
        .NUM_HARTS     (NUM_HARTS),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_PC      (RESET_PC)
    ) u_pc_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (cur_hart_r),
        .rd_pc     (cur_pc_s),
        .inc_en    (issue_s),
        .inc_idx   (cur_hart_r),
        .redir_en  (redirect_valid),
        .redir_idx (redirect_hart),
        .redir_pc  (redirect_pc)
    );

    // Hart pointer advances round-robin on every issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_hart_r <= '0;
        end else if (issue_s) begin
            cur_hart_r <= cur_hart_r + HW'(1);
        end
    end

    // Output register; redirects never touch an instruction already held here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
            out_hart  <= '0;
        end else if (issue_s) begin
            out_valid <= 1'b1;
            out_instr <= instr;
            out_pc    <= cur_pc_s;
            out_hart  <= cur_hart_r;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Saturating count of cycles where downstream back-pressures a valid output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_barrel_fetch.sv
// Scoreboard bench for barrel_fetch: directed sequences push expected (hart, pc, instr)
// triples; a negedge monitor pops and compares every accepted output.
module tb_barrel_fetch;

    typedef struct {
        logic [1:0]  hart;
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_addr;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  out_hart;
    logic        redirect_valid;
    logic [1:0]  redirect_hart;
    logic [31:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    barrel_fetch #(
        .NUM_HARTS     (4),
        .ADDRESS_WIDTH (32),
        .DATA_WIDTH    (32),
        .RESET_PC      (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_addr     (instr_addr),
        .instr          (instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_hart       (out_hart),
        .redirect_valid (redirect_valid),
        .redirect_hart  (redirect_hart),
`ifdef FETCH_STALL_CNT_EN
        .redirect_pc    (redirect_pc),
        .stall_cnt      (stall_cnt)
`else
        .redirect_pc    (redirect_pc)
`endif
    );

    always #5 clk = ~clk;

    // ROM[i] = i, word addressed
    assign instr = instr_addr >> 2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] h, input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.hart = h;
        e.pc   = pc;
        e.ins  = ins;
        exp_q.push_back(e);
    endtask

    task automatic stall_check();
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_hart",  {30'd0, out_hart}, 32'd0);
        chk("stall_pc",    out_pc, 32'h4);
        chk("stall_instr", out_instr, 32'h1);
        chk("stall_addr",  instr_addr, 32'h4);
    endtask

    // Monitor: every handshake seen here is a transfer at the next rising edge
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got hart %0d pc 0x%08h with no expectation", out_hart, out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_hart",  {30'd0, out_hart}, {30'd0, e.hart});
                chk("sb_pc",    out_pc, e.pc);
                chk("sb_instr", out_instr, e.ins);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        redirect_hart  = 2'd0;
        redirect_pc    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pc",    out_pc, 32'd0);
        chk("rst_hart",  {30'd0, out_hart}, 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_addr",  instr_addr, 32'd0);

        // Round-robin start-up stream
        push(2'd0, 32'h0, 32'h0);
        push(2'd1, 32'h0, 32'h0);
        push(2'd2, 32'h0, 32'h0);
        push(2'd3, 32'h0, 32'h0);
        push(2'd0, 32'h4, 32'h1);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        stall_check();

        // Three back-pressured cycles: everything holds
        repeat (3) begin
            @(posedge clk);
            #1;
            stall_check();
        end
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, 32'd3);
`endif

        // Redirect hart 3 while stalled
        redirect_valid = 1'b1;
        redirect_hart  = 2'd3;
        redirect_pc    = 32'h40;
        push(2'd1, 32'h4,        32'h1);
        push(2'd2, 32'h4,        32'h1);
        push(2'd3, 32'h40,       32'h10);
        push(2'd0, 32'h8,        32'h2);
        push(2'd1, 32'h8,        32'h2);
        push(2'd2, 32'h8,        32'h2);
        push(2'd3, 32'h44,       32'h11);
        push(2'd0, 32'hC,        32'h3);
        push(2'd1, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
        push(2'd2, 32'h100,      32'h40);
        push(2'd3, 32'h48,       32'h12);
        push(2'd0, 32'h10,       32'h4);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        // Hart 2 issues at 0x8 on the next edge while redirected to 0x103
        redirect_valid = 1'b1;
        redirect_hart  = 2'd2;
        redirect_pc    = 32'h103;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        // Redirect hart 1 near the top of the address space while hart 0 issues
        redirect_valid = 1'b1;
        redirect_hart  = 2'd1;
        redirect_pc    = 32'hFFFF_FFFD;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("wrap_pc", out_pc, 32'h0);
        chk("wrap_hart", {30'd0, out_hart}, 32'd1);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("held_valid", {31'd0, out_valid}, 32'd1);

        // Reset mid-stall, with a competing redirect that reset must override
        rst_n          = 1'b0;
        redirect_valid = 1'b1;
        redirect_hart  = 2'd0;
        redirect_pc    = 32'h200;
        @(posedge clk);
        #1;
        chk("rst2_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_pc",    out_pc, 32'd0);
        chk("rst2_addr",  instr_addr, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst2_stall_cnt", stall_cnt, 32'd0);
`endif
        redirect_valid = 1'b0;
        push(2'd0, 32'h0, 32'h0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_hart",  {30'd0, out_hart}, 32'd0);
        chk("post_rst_pc",    out_pc, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_fetch.md
BARREL_FETCH -- requirements
Module: barrel_fetch

Interface
REQ-001 SHALL have parameter NUM_HARTS, default 4, number of interleaved harts (power of 2, >=2).
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, PC and instruction-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, instruction width.
REQ-004 SHALL have parameter RESET_PC, default 0, PC value of every hart after reset.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port instr_addr, output, ADDRESS_WIDTH, byte address to the combinational instruction ROM.
REQ-008 SHALL have port instr, input, DATA_WIDTH, ROM word returned in the same cycle.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_instr (output, DATA_WIDTH), out_pc (output, ADDRESS_WIDTH) and out_hart (output, log2(NUM_HARTS)), together forming the decode-side handshake.
REQ-010 SHALL have ports redirect_valid (input, 1), redirect_hart (input, log2(NUM_HARTS)) and redirect_pc (input, ADDRESS_WIDTH), together forming the branch/jump PC update.

Function
REQ-011 SHALL keep one PC register per hart plus a hart pointer cur_hart.
REQ-012 SHALL drive instr_addr = pc[cur_hart] combinationally every cycle.
REQ-013 SHALL define issue = !out_valid || out_ready.
REQ-014 On issue, SHALL load the output register: out_valid<=1, out_instr<=instr, out_pc<=pc[cur_hart], out_hart<=cur_hart.
REQ-015 On issue, SHALL advance pc[cur_hart] by 4, wrapping modulo 2^ADDRESS_WIDTH.
REQ-016 On issue, SHALL advance cur_hart by 1, wrapping from NUM_HARTS-1 to 0.
REQ-017 When out_valid && !out_ready, SHALL hold all outputs, all PCs (except for redirects) and cur_hart unchanged.
REQ-018 Fetch-to-output latency SHALL be 1 cycle, with a throughput of one instruction per cycle when out_ready stays high.
REQ-019 On redirect_valid, SHALL write pc[redirect_hart] <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00}, regardless of stall.
REQ-020 If a redirect and an issue target the same hart in the same cycle, the redirect SHALL win and the +4 increment SHALL be discarded.
REQ-021 A redirect to a hart other than cur_hart SHALL NOT disturb the issue or increment of cur_hart.
REQ-022 SHALL NOT alter or cancel an instruction already held in the output register when a redirect arrives; at most one instruction per hart is in flight, and squashing is downstream's responsibility.
REQ-023 SHALL NOT have a "no valid" state after the first cycle out of reset; fetch is unconditional.

Reset
REQ-024 While rst_n=0 at a clock edge, SHALL set all pc[i]=RESET_PC, cur_hart=0, out_valid=0, out_instr=0, out_pc=0 and out_hart=0.
REQ-025 Reset during a stall SHALL drop the held instruction, and on the first cycle after reset SHALL issue hart 0 at RESET_PC.
REQ-026 Reset SHALL take priority over a redirect in the same cycle.

Configuration
REQ-027 With FETCH_STALL_CNT_EN defined, SHALL add an output stall_cnt (32 bits), reset to 0, incremented each cycle with out_valid && !out_ready, and saturating at 0xFFFFFFFF.
REQ-028 Without FETCH_STALL_CNT_EN, the stall_cnt port and its counter SHALL be absent, with no other behavioural change.

Structure
REQ-029 The shared package SHALL hold the hart-index width (log2 NUM_HARTS), the instruction size constant 4 and the default RESET_PC.
REQ-030 The design SHALL have one sub-module, hart_pc_file: a NUM_HARTS-entry PC register file with one read port indexed by cur_hart, an increment write port and a priority redirect write port.

Verification
REQ-031 Release reset with out_ready=1 and ROM[i]=i -> out_hart sequence is 0,1,2,3,0; out_pc sequence is 0,0,0,0,4; out_instr sequence is 0,0,0,0,1.
REQ-032 Hold out_ready=0 for 3 cycles while out_valid=1 -> outputs, cur_hart and instr_addr stay stable; with the macro defined, stall_cnt rises by 3.
REQ-033 Issue hart 2 at 0x8 while redirect_valid=1, redirect_hart=2, redirect_pc=0x103 in the same cycle -> hart 2's next out_pc is 0x100, not 0xC.
REQ-034 Redirect hart 3 to 0x40 while out_ready=0 -> after the stall releases, hart 3's next out_pc is 0x40.
REQ-035 Set pc[1]=0xFFFFFFFC via redirect -> hart 1 issues at 0xFFFFFFFC and then at 0x0.
REQ-036 Assert rst_n=0 mid-stall with out_valid=1 -> the next cycle has out_valid=0; the first cycle after reset issues hart 0 at RESET_PC.
